uv_br_ctrl: RTL
===============

# uv_br_ctrl

Branch resolution controller between the branch prediction unit, the execution unit and the fetch unit.
- Records every branch/JALR prediction in an in-order queue and checks it against the EXU's resolution.
- On a misprediction or a trap, issues a one-cycle PC redirect and pipeline flush, then clears the queue.
- Stalls fetch when the queue is full and keeps a misprediction counter.

## Interface
- ALEN, 32, address width
- DEPTH, 4, outstanding-prediction queue entries (power of 2, ≥2)
- CNTW, 32, misprediction counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- bp2bc_push  in  1  a predicted branch/JALR leaves BPU this cycle
- bp2bc_pc  in  ALEN  PC of that instruction
- bp2bc_tak  in  1  predicted taken
- bp2bc_tgt  in  ALEN  predicted next PC
- ex2bc_res_vld  in  1  EXU resolves oldest outstanding branch/JALR
- ex2bc_res_tak  in  1  actual taken
- ex2bc_res_tgt  in  ALEN  actual target (valid when taken)
- cs2bc_trap_vld  in  1  trap/return redirect request
- cs2bc_trap_pc  in  ALEN  trap target PC
- bc2if_stall  out  1  queue full, BPU must not push
- bc2if_redir_vld  out  1  redirect pulse
- bc2if_redir_pc  out  ALEN  redirect PC
- bc2pl_flush  out  1  flush IFU/IDU/EXU younger instructions
- bc2cs_err  out  1  sticky protocol error
- bc2cs_mis_cnt  out  CNTW  misprediction count

## Operation
- Queue entry = {pc, tak, tgt}, width 2*ALEN+1.
  - Circular buffer with wr/rd pointers (log2 DEPTH bits) and count (log2 DEPTH + 1 bits); pointers wrap at DEPTH.
- Push: bp2bc_push & state RUN & no flush event this cycle → write at wr_ptr.
  - Push while full (no simultaneous pop) is dropped and sets err.
- Pop: ex2bc_res_vld with count>0 → read head.
  - Resolve with count==0 sets err; no redirect.
- Mispredict = (res_tak != head.tak) | (res_tak & res_tgt != head.tgt).
  - Correct PC = res_tak ? res_tgt : head.pc + 4 (modulo 2^ALEN).
- Flush event = trap_vld | (pop & mispredict). Trap wins; redirect PC = trap_pc.
- On a flush event:
  - Queue cleared (pointers, count ← 0).
  - Same-cycle push discarded (younger than the flushing instruction).
  - mis_cnt increments only for mispredict, even if a trap coincides. Saturates at all-ones.
- States:
  - RUN: normal operation; a flush event → REDIR.
  - REDIR: redir_vld = flush = 1 for exactly this cycle; pushes and resolves ignored. Next state RUN, except trap_vld in REDIR → stay REDIR with the new trap_pc.
- Simultaneous push & pop (no flush): both performed, count unchanged, legal even when full.
- err clears only on rst.

## Timing
- Reset (async, immediate): state RUN, queue empty, all outputs 0 (stall 0, redir_vld 0, redir_pc 0, flush 0, err 0, mis_cnt 0).
- bc2if_stall is combinational from registered count (count==DEPTH); no input-to-stall path.
- Redirect latency: flush event sampled at edge N → redir_vld/redir_pc/flush registered, high during cycle N+1 only.
- Queue clear takes effect at edge N, so a push in cycle N+1 is ignored (REDIR). First accepted push is in cycle N+2.
- mis_cnt and err update at the edge following the causing event.
- Reset mid-REDIR: pulse aborts immediately, outputs 0.

## Structure
- Shared package: entry field widths, state encoding (RUN=0, REDIR=1), instruction-size constant 4.
- Sub-module uv_br_queue: parameterised circular FIFO with push, pop, clear, full, empty, count and head data. All compare/redirect/FSM logic stays in uv_br_ctrl.

## Test plan
- Correct prediction: push {pc=0x100, tak=1, tgt=0x0F0}; resolve tak=1, tgt=0x0F0 → no redirect, count 1→0, mis_cnt 0.
- Direction mispredict: push {0x200, tak=0, tgt=0x204}; resolve tak=1, tgt=0x180 → redir_vld one cycle later with pc 0x180, flush=1, queue empty, mis_cnt=1.
- Not-taken correction: push {0x300, tak=1, tgt=0x2F0}; resolve tak=0 → redirect pc 0x304; with pc=0xFFFFFFFC → redirect pc 0x0 (wrap).
- Full/wrap:
  - Push 4 entries → stall=1; fifth push dropped, err=1.
  - Push+pop in the same cycle while full keeps count 4.
  - Pop 4 with correct resolutions, pointers wrap, no redirect.
- Trap priority: trap_pc=0x8000 in the same cycle as a mispredicting resolve (target 0x180) and a push → redirect 0x8000, push discarded, mis_cnt +1. A trap during REDIR re-issues a pulse with the new PC.
- Error/reset: resolve with empty queue → err=1, no redirect. Assert rst during REDIR → all outputs 0 immediately, count 0.

Source files
------------

// File: rtl/uv_br_ctrl_pkg.sv
// Shared constants for the branch resolution controller: FSM encoding,
// instruction size and queue entry layout helpers.
package uv_br_ctrl_pkg;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  // Fall-through distance for a not-taken branch/JALR
  localparam int INST_BYTES = 4;

  // Entry layout, MSB first: {pc[ALEN], tak, tgt[ALEN]}
  function automatic int entry_w(input int alen);
    return 2 * alen + 1;
  endfunction

endpackage

// File: rtl/uv_br_ctrl_if.sv
// Bundle of BPU/EXU/CSR inputs and IFU/pipeline/CSR outputs of uv_br_ctrl.
interface uv_br_ctrl_if #(
  parameter int ALEN = 32,
  parameter int CNTW = 32
);
  logic            bp2bc_push;
  logic [ALEN-1:0] bp2bc_pc;
  logic            bp2bc_tak;
  logic [ALEN-1:0] bp2bc_tgt;
  logic            ex2bc_res_vld;
  logic            ex2bc_res_tak;
  logic [ALEN-1:0] ex2bc_res_tgt;
  logic            cs2bc_trap_vld;
  logic [ALEN-1:0] cs2bc_trap_pc;
  logic            bc2if_stall;
  logic            bc2if_redir_vld;
  logic [ALEN-1:0] bc2if_redir_pc;
  logic            bc2pl_flush;
  logic            bc2cs_err;
  logic [CNTW-1:0] bc2cs_mis_cnt;

  modport master (
    output bp2bc_push, bp2bc_pc, bp2bc_tak, bp2bc_tgt,
    output ex2bc_res_vld, ex2bc_res_tak, ex2bc_res_tgt,
    output cs2bc_trap_vld, cs2bc_trap_pc,
    input  bc2if_stall, bc2if_redir_vld, bc2if_redir_pc,
    input  bc2pl_flush, bc2cs_err, bc2cs_mis_cnt
  );

  modport slave (
    input  bp2bc_push, bp2bc_pc, bp2bc_tak, bp2bc_tgt,
    input  ex2bc_res_vld, ex2bc_res_tak, ex2bc_res_tgt,
    input  cs2bc_trap_vld, cs2bc_trap_pc,
    output bc2if_stall, bc2if_redir_vld, bc2if_redir_pc,
    output bc2pl_flush, bc2cs_err, bc2cs_mis_cnt
  );
endinterface

// File: rtl/uv_br_queue.sv
// In-order circular FIFO of outstanding predictions; head is readable
// combinationally so the resolution can be checked in the same cycle.
module uv_br_queue #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  input  logic                       clr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

  // A push into a full queue is legal only when the head leaves the same cycle
  assign do_push = push & (~full | pop) & ~clr;
  assign do_pop  = pop & ~empty & ~clr;

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: rtl/uv_br_ctrl.sv
// Branch resolution controller: checks EXU resolutions against queued
// predictions and issues a one-cycle redirect/flush on mispredict or trap.
module uv_br_ctrl
  import uv_br_ctrl_pkg::*;
#(
  parameter int ALEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 32
) (
  input  logic         clk,
  input  logic         rst,
  uv_br_ctrl_if.slave  bc
);
  localparam int EW = entry_w(ALEN);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [0:0]      state_reg, state_next;
  logic [ALEN-1:0] redir_pc_reg, redir_pc_next;
  logic            err_reg, err_next;
  logic [CNTW-1:0] mis_cnt_reg, mis_cnt_next;

  logic            q_full, q_empty;
  logic [AW:0]     q_count;
  logic [EW-1:0]   q_head;
  logic [ALEN-1:0] head_pc, head_tgt, corr_pc;
  logic            head_tak;
  logic            run, pop, mispredict, mis_evt, flush_evt, push_ok;

  assign head_pc  = q_head[EW-1 -: ALEN];
  assign head_tak = q_head[ALEN];
  assign head_tgt = q_head[ALEN-1:0];

  assign run        = (state_reg == ST_RUN);
  assign pop        = run & bc.ex2bc_res_vld & ~q_empty;
  assign mispredict = (bc.ex2bc_res_tak != head_tak) |
                      (bc.ex2bc_res_tak & (bc.ex2bc_res_tgt != head_tgt));
  assign mis_evt    = pop & mispredict;
  assign flush_evt  = bc.cs2bc_trap_vld | mis_evt;
  assign corr_pc    = bc.ex2bc_res_tak ? bc.ex2bc_res_tgt
                                       : head_pc + ALEN'(INST_BYTES);
  // A push in the flushing cycle is younger than the flushing instruction
  assign push_ok    = run & bc.bp2bc_push & ~flush_evt;

  uv_br_queue #(.W(EW), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata ({bc.bp2bc_pc, bc.bp2bc_tak, bc.bp2bc_tgt}),
    .pop   (pop),
    .clr   (flush_evt),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  always_comb begin
    state_next    = flush_evt ? ST_REDIR : ST_RUN;
    redir_pc_next = redir_pc_reg;
    err_next      = err_reg;
    mis_cnt_next  = mis_cnt_reg;
    if (flush_evt) redir_pc_next = bc.cs2bc_trap_vld ? bc.cs2bc_trap_pc : corr_pc;
    if (run && bc.ex2bc_res_vld && q_empty) err_next = 1'b1;
    if (run && bc.bp2bc_push && q_full && !pop && !flush_evt) err_next = 1'b1;
    // Counter counts mispredicts even when a coincident trap owns the redirect
    if (mis_evt && (mis_cnt_reg != {CNTW{1'b1}})) mis_cnt_next = mis_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      redir_pc_reg <= '0;
      err_reg      <= 1'b0;
      mis_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      redir_pc_reg <= redir_pc_next;
      err_reg      <= err_next;
      mis_cnt_reg  <= mis_cnt_next;
    end
  end

  assign bc.bc2if_stall     = (q_count == DEPTH_C);
  assign bc.bc2if_redir_vld = (state_reg == ST_REDIR);
  assign bc.bc2pl_flush     = (state_reg == ST_REDIR);
  assign bc.bc2if_redir_pc  = redir_pc_reg;
  assign bc.bc2cs_err       = err_reg;
  assign bc.bc2cs_mis_cnt   = mis_cnt_reg;
endmodule
